// File: rtl/dice_roll_engine.sv
// Multi-die roll engine: rejection-samples random bytes into die faces,
// emits each face, then a combined result (sum / highest / lowest).
module dice_roll_engine #(
  parameter int RAND_W   = 8,
  parameter int MAX_DICE = 8,
  parameter int SUM_W    = 8,
  localparam int CNT_W   = $clog2(MAX_DICE + 1),
  localparam int IDX_W   = $clog2(MAX_DICE)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [2:0]        i_dieSel,
  input  logic [CNT_W-1:0]  i_count,
  input  logic [1:0]        i_mode,
  input  logic              i_randValid,
  input  logic [RAND_W-1:0] i_randomData,
  output logic              o_randReady,
  output logic              o_busy,
  output logic              o_rollValid,
  output logic [4:0]        o_dieRoll,
  output logic [IDX_W-1:0]  o_dieIndex,
  output logic              o_sumValid,
  output logic [SUM_W-1:0]  o_sum,
  output logic [7:0]        o_rejectCount,
  output logic              o_error
);

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

  localparam int unsigned SPAN = 2 ** RAND_W;

  state_t             state, state_next;
  logic [2:0]         sel_q;
  logic [CNT_W-1:0]   count_q;
  logic [1:0]         mode_q;
  logic [IDX_W-1:0]   idx_q;
  logic [SUM_W-1:0]   acc_q, acc_next;
  logic [4:0]         roll_q;
  logic [IDX_W-1:0]   roll_idx_q;
  logic [SUM_W-1:0]   sum_q;
  logic [7:0]         reject_q;
  logic               error_q;
  logic               cfg_ok, accept, last_die;
  logic [SUM_W-1:0]   face_w;

  // Largest multiple of the side count that fits in the sample range.
  function automatic logic [RAND_W:0] limit_of(input logic [2:0] sel);
    case (sel)
      3'd0:    return (RAND_W+1)'((SPAN / 4)  * 4);
      3'd1:    return (RAND_W+1)'((SPAN / 6)  * 6);
      3'd2:    return (RAND_W+1)'((SPAN / 8)  * 8);
      3'd3:    return (RAND_W+1)'((SPAN / 10) * 10);
      3'd4:    return (RAND_W+1)'((SPAN / 12) * 12);
      default: return (RAND_W+1)'((SPAN / 20) * 20);
    endcase
  endfunction

  // Constant-modulus face mapping, 1-based.
  function automatic logic [4:0] face_of(input logic [2:0] sel, input logic [RAND_W-1:0] r);
    logic [4:0] f;
    case (sel)
      3'd0:    f = 5'(r % 4);
      3'd1:    f = 5'(r % 6);
      3'd2:    f = 5'(r % 8);
      3'd3:    f = 5'(r % 10);
      3'd4:    f = 5'(r % 12);
      default: f = 5'(r % 20);
    endcase
    return f + 5'd1;
  endfunction

  assign cfg_ok   = (i_dieSel < 3'd6) && (i_count != '0) &&
                    (i_count <= CNT_W'(MAX_DICE)) && (i_mode != 2'b11);
  assign accept   = (state == FETCH) && i_randValid &&
                    ({1'b0, i_randomData} < limit_of(sel_q));
  assign last_die = (CNT_W'(idx_q) + CNT_W'(1)) == count_q;
  assign face_w   = SUM_W'(roll_q);

  // Combine the face being emitted into the running result.
  always_comb begin
    acc_next = acc_q;
    case (mode_q)
      2'b00:   acc_next = acc_q + face_w;
      2'b01:   acc_next = (idx_q == '0 || face_w > acc_q) ? face_w : acc_q;
      default: acc_next = (idx_q == '0 || face_w < acc_q) ? face_w : acc_q;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start && cfg_ok) state_next = FETCH;
      FETCH:   if (accept) state_next = EMIT;
      EMIT:    state_next = last_die ? DONE : FETCH;
      default: state_next = IDLE;
    endcase
  end

  // State register and roll datapath.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      sel_q      <= '0;
      count_q    <= '0;
      mode_q     <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      roll_q     <= '0;
      roll_idx_q <= '0;
      sum_q      <= '0;
      reject_q   <= '0;
      error_q    <= 1'b0;
    end else begin
      state   <= state_next;
      error_q <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            if (cfg_ok) begin
              sel_q    <= i_dieSel;
              count_q  <= i_count;
              mode_q   <= i_mode;
              acc_q    <= '0;
              idx_q    <= '0;
              reject_q <= '0;
              sum_q    <= '0;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (accept) begin
            roll_q     <= face_of(sel_q, i_randomData);
            roll_idx_q <= idx_q;
          end else if (i_randValid && reject_q != '1) begin
            reject_q <= reject_q + 8'd1;
          end
        end
        EMIT: begin
          acc_q <= acc_next;
          if (last_die) sum_q <= acc_next;
          else          idx_q <= idx_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_randReady   = (state == FETCH);
  assign o_busy        = (state != IDLE);
  assign o_rollValid   = (state == EMIT);
  assign o_sumValid    = (state == DONE);
  assign o_dieRoll     = roll_q;
  assign o_dieIndex    = roll_idx_q;
  assign o_sum         = sum_q;
  assign o_rejectCount = reject_q;
  assign o_error       = error_q;

endmodule

// File: tb/tb_dice_roll_engine.sv
// Directed self-checking bench for dice_roll_engine.
module tb_dice_roll_engine;

  logic       clk = 1'b0;
  logic       reset_n, start, rand_valid;
  logic [2:0] die_sel;
  logic [3:0] count;
  logic [1:0] mode;
  logic [7:0] random_data;
  logic       rand_ready, busy, roll_valid, sum_valid, error;
  logic [4:0] die_roll;
  logic [2:0] die_index;
  logic [7:0] sum, reject_count;

  int total = 0;
  int bad   = 0;
  int samp_q[$];
  int exp_face[$];

  dice_roll_engine #(.RAND_W(8), .MAX_DICE(8), .SUM_W(8)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_dieSel(die_sel),
    .i_count(count), .i_mode(mode), .i_randValid(rand_valid),
    .i_randomData(random_data), .o_randReady(rand_ready), .o_busy(busy),
    .o_rollValid(roll_valid), .o_dieRoll(die_roll), .o_dieIndex(die_index),
    .o_sumValid(sum_valid), .o_sum(sum), .o_rejectCount(reject_count),
    .o_error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_ready"}, rand_ready, 0);
    check({name, "_rollv"}, roll_valid, 0);
    check({name, "_roll"}, die_roll, 0);
    check({name, "_index"}, die_index, 0);
    check({name, "_sumv"}, sum_valid, 0);
    check({name, "_sum"}, sum, 0);
    check({name, "_rej"}, reject_count, 0);
    check({name, "_err"}, error, 0);
  endtask

  // Runs one roll feeding samp_q (valid held high while samples remain).
  task automatic run_roll(input logic [2:0] sel, input logic [3:0] cnt,
                          input logic [1:0] md, input int exp_sum,
                          input int exp_rej, input int exp_cyc, input string name);
    int ptr, ridx, cyc;
    bit done;
    die_sel = sel; count = cnt; mode = md; start = 1'b1; rand_valid = 1'b0;
    step();
    start = 1'b0; cyc = 1; ptr = 0; ridx = 0; done = 0;
    check({name, "_busy"}, busy, 1);
    while (!done && cyc < 200) begin
      if (roll_valid) begin
        if (ridx < exp_face.size()) begin
          check({name, "_face"}, die_roll, exp_face[ridx]);
          check({name, "_idx"}, die_index, ridx);
        end else begin
          check({name, "_nrolls"}, ridx + 1, exp_face.size());
        end
        ridx++;
      end
      if (sum_valid) begin
        check({name, "_sum"}, sum, exp_sum);
        check({name, "_rej"}, reject_count, exp_rej);
        check({name, "_lat"}, cyc, exp_cyc);
        check({name, "_nrolls"}, ridx, exp_face.size());
        done = 1;
      end
      if (ptr < samp_q.size()) begin
        rand_valid  = 1'b1;
        random_data = 8'(samp_q[ptr]);
        if (rand_ready) ptr++;
      end else begin
        rand_valid = 1'b0;
      end
      if (!done) begin
        step();
        cyc++;
      end
    end
    if (!done) check({name, "_timeout"}, cyc, exp_cyc);
    rand_valid = 1'b0;
    step();
    check({name, "_idle"}, busy, 0);
    check({name, "_hold"}, sum, exp_sum);
  endtask

  initial begin
    int ridx, seen_sum, ptr;
    logic [2:0] bad_sel [4];
    logic [3:0] bad_cnt [4];
    logic [1:0] bad_md  [4];

    // Reset held with start asserted.
    reset_n = 1'b0; start = 1'b1; die_sel = 3'd1; count = 4'd1; mode = 2'd0;
    rand_valid = 1'b0; random_data = '0;
    repeat (3) step();
    check_all_zero("reset");
    start = 1'b0; reset_n = 1'b1;
    step();
    check("post_reset_busy", busy, 0);

    // D6 x3 sum: 17 -> 6, 253 rejected, 0 -> 1, 11 -> 6.
    samp_q = '{17, 253, 0, 11}; exp_face = '{6, 1, 6};
    run_roll(3'd1, 4'd3, 2'd0, 13, 1, 8, "d6sum");

    // D20 x2 keep highest: 239 -> 20, 240 rejected, 19 -> 20.
    samp_q = '{239, 240, 19}; exp_face = '{20, 20};
    run_roll(3'd5, 4'd2, 2'd1, 20, 1, 6, "d20max");

    // D20 x2 keep lowest: 5 -> 6, 19 -> 20.
    samp_q = '{5, 19}; exp_face = '{6, 20};
    run_roll(3'd5, 4'd2, 2'd2, 6, 0, 5, "d20min");

    // Handshake stall on D8 x1.
    die_sel = 3'd2; count = 4'd1; mode = 2'd0; start = 1'b1;
    step();
    start = 1'b0; rand_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_ready", rand_ready, 1);
      check("stall_rollv", roll_valid, 0);
      step();
    end
    rand_valid = 1'b1; random_data = 8'd255;
    step();
    rand_valid = 1'b0;
    check("stall_rollv_hi", roll_valid, 1);
    check("stall_face", die_roll, 8);
    check("stall_idx", die_index, 0);
    step();
    check("stall_sumv", sum_valid, 1);
    check("stall_sum", sum, 8);
    check("stall_rej", reject_count, 0);
    step();
    check("stall_idle", busy, 0);

    // Invalid configurations.
    bad_sel = '{3'd6, 3'd1, 3'd1, 3'd7};
    bad_cnt = '{4'd1, 4'd0, 4'd2, 4'd9};
    bad_md  = '{2'd0, 2'd0, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      die_sel = bad_sel[i]; count = bad_cnt[i]; mode = bad_md[i]; start = 1'b1;
      step();
      start = 1'b0;
      check("inv_err", error, 1);
      check("inv_busy", busy, 0);
      check("inv_ready", rand_ready, 0);
      step();
      check("inv_err_off", error, 0);
      check("inv_busy2", busy, 0);
    end

    // D12 x4 with ignored restart, aborted by reset after the 2nd face.
    samp_q = '{5, 7, 9, 11}; exp_face = '{6, 8};
    die_sel = 3'd4; count = 4'd4; mode = 2'd0; start = 1'b1;
    step();
    start = 1'b0; ridx = 0; seen_sum = 0; ptr = 0;
    for (int cyc = 1; cyc < 50 && ridx < 2; cyc++) begin
      if (cyc == 1) begin
        start = 1'b1; die_sel = 3'd0; count = 4'd1;
      end else begin
        start = 1'b0;
      end
      if (sum_valid) seen_sum++;
      if (roll_valid) begin
        check("abort_face", die_roll, exp_face[ridx]);
        check("abort_idx", die_index, ridx);
        ridx++;
      end
      if (ridx < 2) begin
        rand_valid  = 1'b1;
        random_data = 8'(samp_q[ptr]);
        if (rand_ready) ptr++;
        step();
      end
    end
    check("abort_rolls", ridx, 2);
    check("abort_busy", busy, 1);
    start = 1'b0; rand_valid = 1'b0; reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_all_zero("abort");
    for (int i = 0; i < 4; i++) begin
      if (sum_valid) seen_sum++;
      step();
    end
    check("abort_nosum", seen_sum, 0);
    check("abort_idle", busy, 0);

    // Fresh D4 x1 after abort: 3 -> 4.
    samp_q = '{3}; exp_face = '{4};
    run_roll(3'd0, 4'd1, 2'd0, 4, 0, 3, "d4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
